l2_arbiter: RTL
===============

# l2_arbiter

Two-port arbiter that shares the single L2 / victim-cache request port between the instruction-side and data-side L1 cache miss paths. It accepts line-granularity read requests from the I-cache and read or write requests from the D-cache. It grants one requester at a time using round-robin priority and latches the winner's address and write data. It then drives the downstream port with stable strobes until the response, and routes that response back to the owner only. It sits between the two L1 cache controllers and the L2 cache, which fronts the victim cache and physical memory.

## Interface
- ADDR_WIDTH, 16, byte address width (lc3b_word)
- LINE_WIDTH, 128, cache line width in bits
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- i_read  in  1  I-side line read request; level, held until i_resp
- i_address  in  ADDR_WIDTH  I-side line address
- i_resp  out  1  I-side response strobe, one cycle
- i_rdata  out  LINE_WIDTH  I-side read data; valid when i_resp=1
- d_read  in  1  D-side line read request; level, held until d_resp
- d_write  in  1  D-side line write request; level, held until d_resp
- d_address  in  ADDR_WIDTH  D-side line address
- d_wdata  in  LINE_WIDTH  D-side write line
- d_resp  out  1  D-side response strobe, one cycle
- d_rdata  out  LINE_WIDTH  D-side read data; valid when d_resp=1
- l2_read  out  1  downstream read strobe
- l2_write  out  1  downstream write strobe
- l2_address  out  ADDR_WIDTH  downstream address, taken from the latch
- l2_wdata  out  LINE_WIDTH  downstream write data, taken from the latch
- l2_resp  in  1  downstream completion
- l2_rdata  in  LINE_WIDTH  downstream read data

## Operation
- States: IDLE, SERVE_I, SERVE_D, RELEASE. State is a registered enum; all outputs are combinational from state and latches.
- IDLE: no downstream strobes, no responses.
  - Only i_read pending: latch i_address, op=read; next SERVE_I.
  - Only d_read or d_write pending: latch d_address, d_wdata and op; next SERVE_D.
  - Both pending: grant the side opposite last_grant, then update last_grant to the winner.
- d_read and d_write both high is illegal. The arbiter treats it as a write.
- SERVE_I: l2_read=1; l2_address=latched address.
  - i_resp=l2_resp; i_rdata=l2_rdata (combinational passthrough).
  - On l2_resp, next state is RELEASE.
- SERVE_D: l2_read or l2_write per latched op; l2_address and l2_wdata come from the latches.
  - d_resp=l2_resp; d_rdata=l2_rdata.
  - On l2_resp, next state is RELEASE.
- RELEASE: one bubble cycle. No strobes, no responses, requests ignored. Requesters drop their request here. Next state is IDLE.
- last_grant: 1-bit register; 0=I, 1=D. Reset value is 1, so I wins the first tie.
- i_rdata and d_rdata always carry l2_rdata. Only the resp strobe is gated by ownership.
- l2_resp in IDLE or RELEASE is ignored and is never forwarded.
- A requester deasserting mid-transaction is illegal. The transaction still completes on the latched values and the resp is still issued.
- A non-owner request arriving mid-transaction waits and is sampled only in IDLE.

## Timing
- Reset: state=IDLE, last_grant=1, address/wdata/op latches cleared to 0.
  - All outputs are 0 in the cycle after the reset edge: l2_read, l2_write, i_resp, d_resp=0; l2_address=0, l2_wdata=0.
- Reset mid-transaction drops the strobes the cycle after the edge. The in-flight downstream access is abandoned with no response to either side.
- Grant latency: a request first seen in IDLE at edge T drives the downstream strobe from cycle T+1.
- Response latency equals downstream latency, with 0 added cycles. The resp strobe is exactly one cycle, in the same cycle as l2_resp.
- Minimum occupancy per transaction: 3 cycles (IDLE, SERVE with immediate l2_resp, RELEASE).
- Back-to-back: requester B, pending throughout A's transaction, is granted at the IDLE after RELEASE.
- Fairness: with both sides continuously requesting, grants strictly alternate I, D, I, D.
- l2_address, l2_wdata and the op are stable for the whole SERVE state regardless of input changes.

## Test plan
- Reset, then i_read=1, i_address=0x1230; l2_resp after 4 cycles with l2_rdata=0xA5…A5 -> l2_read high for 4 cycles with l2_address=0x1230; i_resp=1 for one cycle with i_rdata=0xA5…A5; d_resp stays 0.
- d_write=1, d_address=0x4450, d_wdata=0x1111…; change d_address to 0x9990 mid-SERVE -> l2_write=1 with l2_address=0x4450 throughout; one-cycle d_resp.
- Simultaneous i_read and d_read held continuously for 4 transactions after reset -> grant order I, D, I, D; one RELEASE cycle between each.
- l2_resp pulsed while IDLE and while in RELEASE -> no i_resp or d_resp; state unchanged (IDLE stays IDLE, RELEASE goes to IDLE).
- Reset asserted during SERVE_D -> next cycle l2_write=0 and d_resp=0; after reset, a tie grants I first.
- d_read and d_write both high with d_address=0x0010 -> l2_write=1, l2_read=0; d_resp returned on l2_resp.

Source files
------------

// File: rtl/l2_arbiter.sv
// l2_arbiter: shares the single L2 request port between the I-cache and
// D-cache miss paths. Round-robin grant, latched address/data/op, response
// routed back to the owning side only, one RELEASE bubble per transaction.
module l2_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset,
  // I-side (read only)
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic                  i_resp,
  output logic [LINE_WIDTH-1:0] i_rdata,
  // D-side (read or write)
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic                  d_resp,
  output logic [LINE_WIDTH-1:0] d_rdata,
  // downstream L2 port
  output logic                  l2_read,
  output logic                  l2_write,
  output logic [ADDR_WIDTH-1:0] l2_address,
  output logic [LINE_WIDTH-1:0] l2_wdata,
  input  logic                  l2_resp,
  input  logic [LINE_WIDTH-1:0] l2_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RELEASE = 2'd3
  } state_e;

  state_e                  state_q;
  logic                    last_grant_q;  // 0 = I, 1 = D
  logic                    op_wr_q;       // latched op: 1 = write
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LINE_WIDTH-1:0]   wdata_q;

  logic i_req, d_req, grant_d;

  // Round-robin pick: D wins if it is alone, or on a tie when I went last.
  always_comb begin
    i_req   = i_read;
    d_req   = d_read | d_write;
    grant_d = d_req & (~i_req | ~last_grant_q);
  end

  // Arbitration FSM plus request latches; latches only load on a grant so
  // the downstream view stays frozen for the whole SERVE state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      op_wr_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            state_q      <= SERVE_D;
            last_grant_q <= 1'b1;
            addr_q       <= d_address;
            wdata_q      <= d_wdata;
            // read+write together is illegal; treat it as a write
            op_wr_q      <= d_write;
          end else if (i_req) begin
            state_q      <= SERVE_I;
            last_grant_q <= 1'b0;
            addr_q       <= i_address;
            op_wr_q      <= 1'b0;
          end
        end
        SERVE_I, SERVE_D: begin
          if (l2_resp) state_q <= RELEASE;
        end
        RELEASE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Downstream strobes and owner-gated response strobes; read data is a
  // plain passthrough to both sides.
  always_comb begin
    l2_read    = (state_q == SERVE_I) | ((state_q == SERVE_D) & ~op_wr_q);
    l2_write   = (state_q == SERVE_D) & op_wr_q;
    l2_address = addr_q;
    l2_wdata   = wdata_q;
    i_resp     = (state_q == SERVE_I) & l2_resp;
    d_resp     = (state_q == SERVE_D) & l2_resp;
    i_rdata    = l2_rdata;
    d_rdata    = l2_rdata;
  end

endmodule
